dmem_arbiter: RTL and testbench

Two-requester arbiter and wait-state sequencer for the single-port data memory (`async_mem` dmem instance) in the pipelined MIPS. It shares the memory between the pipeline MEM stage (CPU port) and a debug/loader port, stretches every access to a programmable number of wait states, and returns a stall to the pipeline until the CPU access completes. It sits between the pipeline's MEM-stage signals and the dmem instance ports.

---
 rtl/dmem_arb_pkg.sv | 27 ++
 rtl/dmem_arbiter_wait_counter.sv | 43 ++++
 rtl/dmem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, owner
// identifiers, wait-state counter width and the latched request record.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    // Width of the wait-state down-counter (WAIT_STATES range 0..15)
    localparam int WAIT_W = 4;

    // Arbiter FSM states
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] DONE   = 2'b10;

    // Requester identifiers
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    // Request fields captured from the winning port at grant time
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Loadable down-counter that times the wait states of one memory access.
// Ports:
//   clk      system clock
//   reset    asynchronous active-low reset (counter clears to 0)
//   load     load load_val this cycle (has priority over en)
//   load_val value to load
//   en       decrement by one; holds at zero
//   value    current count
//   zero     count equals zero
// -----------------------------------------------------------------------------
module wait_counter
    import dmem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              en,
    output logic [WAIT_W-1:0] value,
    output logic              zero
);

    logic [WAIT_W-1:0] count_r;

    // Counter register: load wins over decrement, saturates at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {WAIT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {WAIT_W{1'b0}})) begin
            count_r <= count_r - WAIT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign value = count_r;
    assign zero  = (count_r == {WAIT_W{1'b0}});

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the pipeline MEM stage (CPU port)
// and a debug/loader port. Each access is stretched by WAIT_STATES extra
// cycles; the CPU is stalled until its own access completes.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request (held until cpu_ack)
//   cpu_rdata, cpu_ack         registered load data, one-cycle completion pulse
//   cpu_stall                  cpu_req & ~cpu_ack
//   dbg_req/we/addr/wdata      debug request, same protocol as CPU
//   dbg_rdata, dbg_ack         debug load data and completion pulse
//   mem_write/addr/wdata       to the dmem instance
//   mem_rdata                  combinational read data from dmem
//   busy                       FSM not in IDLE
//   owner                      0 = CPU, 1 = debug; current/last grant
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic [31:0] dbg_rdata,
    output logic        dbg_ack,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic              owner_r;
    logic              last_owner_r;
    mem_req_t          lat_r;
    mem_req_t          win_s;
    logic              mem_write_r;
    logic              cpu_ack_r;
    logic              dbg_ack_r;
    logic [31:0]       cpu_rdata_r;
    logic [31:0]       dbg_rdata_r;
    logic              grant_s;
    logic              winner_s;
    logic              final_s;
    logic              cnt_en_s;
    logic              cnt_zero_s;
    logic [WAIT_W-1:0] cnt_value_s;

    // Arbitration: only sampled in IDLE; a tie goes to whoever did not win last
    always_comb begin
        grant_s  = 1'b0;
        winner_s = OWN_CPU;
        if (state_r == IDLE) begin
            case ({cpu_req, dbg_req})
                2'b10: begin
                    grant_s  = 1'b1;
                    winner_s = OWN_CPU;
                end
                2'b01: begin
                    grant_s  = 1'b1;
                    winner_s = OWN_DBG;
                end
                2'b11: begin
                    grant_s  = 1'b1;
                    winner_s = ~last_owner_r;
                end
                default: begin
                    grant_s  = 1'b0;
                    winner_s = OWN_CPU;
                end
            endcase
        end else begin
            grant_s  = 1'b0;
            winner_s = OWN_CPU;
        end
    end

    // Select the request fields of the winning port
    always_comb begin
        win_s = '0;
        if (winner_s == OWN_DBG) begin
            win_s.we    = dbg_we;
            win_s.addr  = dbg_addr;
            win_s.wdata = dbg_wdata;
        end else begin
            win_s.we    = cpu_we;
            win_s.addr  = cpu_addr;
            win_s.wdata = cpu_wdata;
        end
    end

    // Last ACCESS cycle: counter has run out
    assign final_s  = (state_r == ACCESS) && cnt_zero_s;
    assign cnt_en_s = (state_r == ACCESS) && !cnt_zero_s;

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_zero_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state, ownership and request latch (fields frozen until next grant)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            owner_r      <= OWN_CPU;
            last_owner_r <= OWN_DBG;
            lat_r        <= '0;
        end else begin
            state_r <= state_next_s;
            if (grant_s) begin
                owner_r      <= winner_s;
                last_owner_r <= winner_s;
                lat_r        <= win_s;
            end
        end
    end

    // Write strobe, registered one cycle ahead so it is high exactly in the
    // final ACCESS cycle: from the grant when there are no wait states,
    // otherwise when the counter is about to reach zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_write_r <= 1'b0;
        end else if (grant_s) begin
            mem_write_r <= win_s.we && (WAIT_LOAD == 4'd0);
        end else if (cnt_en_s) begin
            mem_write_r <= lat_r.we && (cnt_value_s == 4'd1);
        end else begin
            mem_write_r <= 1'b0;
        end
    end

    // Completion: ack pulse in DONE, load data captured at the end of ACCESS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack_r   <= 1'b0;
            dbg_ack_r   <= 1'b0;
            cpu_rdata_r <= 32'h0000_0000;
            dbg_rdata_r <= 32'h0000_0000;
        end else begin
            cpu_ack_r <= final_s && (owner_r == OWN_CPU);
            dbg_ack_r <= final_s && (owner_r == OWN_DBG);
            if (final_s && !lat_r.we) begin
                if (owner_r == OWN_CPU) begin
                    cpu_rdata_r <= mem_rdata;
                end else begin
                    dbg_rdata_r <= mem_rdata;
                end
            end
        end
    end

    wait_counter u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_s),
        .load_val (WAIT_LOAD),
        .en       (cnt_en_s),
        .value    (cnt_value_s),
        .zero     (cnt_zero_s)
    );

    assign cpu_rdata = cpu_rdata_r;
    assign cpu_ack   = cpu_ack_r;
    assign cpu_stall = cpu_req & ~cpu_ack_r;
    assign dbg_rdata = dbg_rdata_r;
    assign dbg_ack   = dbg_ack_r;
    assign mem_write = mem_write_r;
    assign mem_addr  = lat_r.addr;
    assign mem_wdata = lat_r.wdata;
    assign busy      = (state_r != IDLE);
    assign owner     = owner_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter: instance A uses the default two wait
// states, instance B uses zero. Each instance drives its own memory model.
// Expected acks (cycle and read data) are queued when a request is issued and
// checked when the ack pulse appears.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        reset;

    logic        cpu_req_a, cpu_we_a, cpu_ack_a, cpu_stall_a;
    logic [31:0] cpu_addr_a, cpu_wdata_a, cpu_rdata_a;
    logic        dbg_req_a, dbg_we_a, dbg_ack_a;
    logic [31:0] dbg_addr_a, dbg_wdata_a, dbg_rdata_a;
    logic        mem_write_a, busy_a, owner_a;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;

    logic        cpu_req_b, cpu_we_b, cpu_ack_b, cpu_stall_b;
    logic [31:0] cpu_addr_b, cpu_wdata_b, cpu_rdata_b;
    logic        dbg_req_b, dbg_we_b, dbg_ack_b;
    logic [31:0] dbg_addr_b, dbg_wdata_b, dbg_rdata_b;
    logic        mem_write_b, busy_b, owner_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    int          n_checks;
    int          n_pass;
    int          cyc;
    int          stall_cnt;
    bit          drop_cpu_a, drop_dbg_a, adv_b;
    exp_t        cpu_a_q[$];
    exp_t        dbg_a_q[$];
    exp_t        cpu_b_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] b_next_q[$];

    dmem_arbiter #(.WAIT_STATES(2)) dut_a (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req_a), .cpu_we(cpu_we_a), .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a),
        .cpu_rdata(cpu_rdata_a), .cpu_ack(cpu_ack_a), .cpu_stall(cpu_stall_a),
        .dbg_req(dbg_req_a), .dbg_we(dbg_we_a), .dbg_addr(dbg_addr_a), .dbg_wdata(dbg_wdata_a),
        .dbg_rdata(dbg_rdata_a), .dbg_ack(dbg_ack_a),
        .mem_write(mem_write_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_rdata(mem_rdata_a), .busy(busy_a), .owner(owner_a)
    );

    dmem_arbiter #(.WAIT_STATES(0)) dut_b (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
        .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b), .cpu_stall(cpu_stall_b),
        .dbg_req(dbg_req_b), .dbg_we(dbg_we_b), .dbg_addr(dbg_addr_b), .dbg_wdata(dbg_wdata_b),
        .dbg_rdata(dbg_rdata_b), .dbg_ack(dbg_ack_b),
        .mem_write(mem_write_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .busy(busy_b), .owner(owner_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: combinational read, write on the rising edge
    assign mem_rdata_a = mem_a[mem_addr_a[9:2]];
    assign mem_rdata_b = mem_b[mem_addr_b[9:2]];

    always @(posedge clk) begin
        if (mem_write_a) mem_a[mem_addr_a[9:2]] <= mem_wdata_a;
        if (mem_write_b) mem_b[mem_addr_b[9:2]] <= mem_wdata_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, then advance past the rising edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (cpu_ack_a) begin
            check("cpu_a_ack_expected", 32'(cpu_a_q.size() != 0), 32'd1);
            if (cpu_a_q.size() != 0) begin
                e = cpu_a_q.pop_front();
                check("cpu_a_ack_cycle", cyc, e.cyc);
                check("cpu_a_rdata", cpu_rdata_a, e.rdata);
            end
            drop_cpu_a = 1'b1;
        end
        if (dbg_ack_a) begin
            check("dbg_a_ack_expected", 32'(dbg_a_q.size() != 0), 32'd1);
            if (dbg_a_q.size() != 0) begin
                e = dbg_a_q.pop_front();
                check("dbg_a_ack_cycle", cyc, e.cyc);
                check("dbg_a_rdata", dbg_rdata_a, e.rdata);
            end
            drop_dbg_a = 1'b1;
        end
        if (cpu_ack_b) begin
            check("cpu_b_ack_expected", 32'(cpu_b_q.size() != 0), 32'd1);
            if (cpu_b_q.size() != 0) begin
                e = cpu_b_q.pop_front();
                check("cpu_b_ack_cycle", cyc, e.cyc);
                check("cpu_b_rdata", cpu_rdata_b, e.rdata);
            end
            adv_b = 1'b1;
        end
        if (mem_write_a) wr_q.push_back(cyc);
        if (cpu_stall_a) stall_cnt++;
        @(posedge clk);
        #1;
        cyc++;
        if (drop_cpu_a) begin
            cpu_req_a  = 1'b0;
            drop_cpu_a = 1'b0;
        end
        if (drop_dbg_a) begin
            dbg_req_a  = 1'b0;
            drop_dbg_a = 1'b0;
        end
        if (adv_b) begin
            if (b_next_q.size() != 0) begin
                cpu_addr_b = b_next_q.pop_front();
            end else begin
                cpu_req_b = 1'b0;
            end
            adv_b = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; stall_cnt = 0;
        drop_cpu_a = 1'b0; drop_dbg_a = 1'b0; adv_b = 1'b0;
        reset = 1'b0;
        cpu_req_a = 1'b0; cpu_we_a = 1'b0; cpu_addr_a = 32'h0; cpu_wdata_a = 32'h0;
        dbg_req_a = 1'b0; dbg_we_a = 1'b0; dbg_addr_a = 32'h0; dbg_wdata_a = 32'h0;
        cpu_req_b = 1'b0; cpu_we_b = 1'b0; cpu_addr_b = 32'h0; cpu_wdata_b = 32'h0;
        dbg_req_b = 1'b0; dbg_we_b = 1'b0; dbg_addr_b = 32'h0; dbg_wdata_b = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[8'h10] = 32'hDEAD_BEEF;   // 0x40
        mem_a[8'h11] = 32'hCAFE_F00D;   // 0x44
        mem_a[8'h30] = 32'h0BAD_F00D;   // 0xC0
        mem_b[8'h40] = 32'h1111_1111;   // 0x100
        mem_b[8'h41] = 32'h2222_2222;   // 0x104
        mem_b[8'h42] = 32'h3333_3333;   // 0x108
        mem_b[8'h43] = 32'h4444_4444;   // 0x10C

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_mem_write_a", 32'(mem_write_a), 32'd0);
        check("rst_acks_a", 32'({cpu_ack_a, dbg_ack_a}), 32'd0);
        check("rst_cpu_rdata_a", cpu_rdata_a, 32'h0);
        check("rst_dbg_rdata_a", dbg_rdata_a, 32'h0);
        check("rst_mem_addr_a", mem_addr_a, 32'h0);
        check("rst_mem_wdata_a", mem_wdata_a, 32'h0);
        check("rst_owner_a", 32'(owner_a), 32'd0);
        check("rst_b_flags", 32'({busy_b, owner_b, cpu_ack_b, dbg_ack_b, cpu_stall_b, mem_write_b}), 32'd0);
        check("rst_b_data", mem_addr_b | mem_wdata_b | cpu_rdata_b | dbg_rdata_b, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Contention right after reset: CPU wins first tie, debug follows
        cyc = 0; stall_cnt = 0;
        cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 32'h40;
        dbg_req_a = 1'b1; dbg_we_a = 1'b0; dbg_addr_a = 32'h44;
        cpu_a_q.push_back('{cyc: 32'd4, rdata: 32'hDEAD_BEEF});
        dbg_a_q.push_back('{cyc: 32'd9, rdata: 32'hCAFE_F00D});
        repeat (12) tick();
        check("cont1_cpu_stall_cycles", stall_cnt, 32'd4);
        check("cont1_owner_dbg", 32'(owner_a), 32'd1);
        check("cont1_drained", 32'(cpu_a_q.size() + dbg_a_q.size()), 32'd0);

        // Solo CPU load
        cyc = 0; stall_cnt = 0;
        cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 32'h44;
        cpu_a_q.push_back('{cyc: 32'd4, rdata: 32'hCAFE_F00D});
        repeat (6) tick();
        check("load_stall_cycles", stall_cnt, 32'd4);
        check("load_idle_busy", 32'(busy_a), 32'd0);

        // Contention after a CPU win: debug goes first
        cyc = 0;
        cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 32'h40;
        dbg_req_a = 1'b1; dbg_we_a = 1'b0; dbg_addr_a = 32'hC0;
        dbg_a_q.push_back('{cyc: 32'd4, rdata: 32'h0BAD_F00D});
        cpu_a_q.push_back('{cyc: 32'd9, rdata: 32'hDEAD_BEEF});
        repeat (12) tick();
        check("cont2_owner_cpu", 32'(owner_a), 32'd0);
        check("cont2_drained", 32'(cpu_a_q.size() + dbg_a_q.size()), 32'd0);

        // CPU store: one write strobe in cycle 3, rdata untouched
        cyc = 0; wr_q.delete();
        cpu_req_a = 1'b1; cpu_we_a = 1'b1; cpu_addr_a = 32'h80; cpu_wdata_a = 32'h1234_5678;
        cpu_a_q.push_back('{cyc: 32'd4, rdata: 32'hDEAD_BEEF});
        repeat (6) tick();
        check("store_write_count", 32'(wr_q.size()), 32'd1);
        check("store_write_cycle", (wr_q.size() != 0) ? wr_q[0] : 32'hFFFF_FFFF, 32'd3);
        check("store_mem", mem_a[8'h20], 32'h1234_5678);

        // Debug store with request dropped in cycle 2: still completes
        cyc = 0; wr_q.delete();
        dbg_req_a = 1'b1; dbg_we_a = 1'b1; dbg_addr_a = 32'h90; dbg_wdata_a = 32'hA5A5_A5A5;
        dbg_a_q.push_back('{cyc: 32'd4, rdata: 32'h0BAD_F00D});
        repeat (2) tick();
        dbg_req_a = 1'b0;
        dbg_addr_a = 32'h44; dbg_wdata_a = 32'h0;
        repeat (4) tick();
        check("abort_write_count", 32'(wr_q.size()), 32'd1);
        check("abort_write_cycle", (wr_q.size() != 0) ? wr_q[0] : 32'hFFFF_FFFF, 32'd3);
        check("abort_mem", mem_a[8'h24], 32'hA5A5_A5A5);
        check("abort_drained", 32'(dbg_a_q.size()), 32'd0);

        // Reset asserted during the final cycle of a CPU store
        cyc = 0;
        cpu_req_a = 1'b1; cpu_we_a = 1'b1; cpu_addr_a = 32'hC0; cpu_wdata_a = 32'h5555_5555;
        repeat (3) tick();
        #2;
        check("rst_mid_write_seen", 32'(mem_write_a), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_mem_write", 32'(mem_write_a), 32'd0);
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_acks", 32'({cpu_ack_a, dbg_ack_a}), 32'd0);
        check("rst_mid_rdata", cpu_rdata_a, 32'h0);
        check("rst_mid_mem_addr", mem_addr_a, 32'h0);
        cpu_req_a = 1'b0; cpu_we_a = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_mid_mem_kept", mem_a[8'h30], 32'h0BAD_F00D);
        repeat (3) tick();
        check("rst_mid_idle", 32'(busy_a), 32'd0);

        // Zero wait states: single load, then three back-to-back loads
        cyc = 0;
        cpu_req_b = 1'b1; cpu_we_b = 1'b0; cpu_addr_b = 32'h100;
        cpu_b_q.push_back('{cyc: 32'd2, rdata: 32'h1111_1111});
        repeat (4) tick();
        cyc = 0;
        cpu_req_b = 1'b1; cpu_addr_b = 32'h104;
        b_next_q.push_back(32'h108);
        b_next_q.push_back(32'h10C);
        cpu_b_q.push_back('{cyc: 32'd2, rdata: 32'h2222_2222});
        cpu_b_q.push_back('{cyc: 32'd5, rdata: 32'h3333_3333});
        cpu_b_q.push_back('{cyc: 32'd8, rdata: 32'h4444_4444});
        repeat (11) tick();
        check("b_drained", 32'(cpu_b_q.size()), 32'd0);
        check("b_idle", 32'({busy_b, cpu_req_b}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
